// File: rtl/spi_cfg_sequencer.sv
// spi_cfg_sequencer: SPI master (mode 0) that writes the eight channel
// configuration registers of the SPI config block from a parallel image.
// Optional build macro: SPI_CFG_READBACK_EN adds a read frame after every
// write frame and flags the first channel whose readback differs.
module spi_cfg_sequencer #(
  parameter int CLK_DIV   = 2,
  parameter int BASE_ADDR = 0,
  parameter int DATA_W    = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic [8*DATA_W-1:0] ch_data,
  input  logic [7:0]          ch_mask,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [2:0]          err_ch,
  output logic                sclk,
  output logic                cs_n,
  output logic                mosi,
  input  logic                miso
);

  localparam int NCH = 8;
  localparam int FW  = 8 + DATA_W;
  localparam int CW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [3:0]    BIT_LAST = 4'(FW - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SCAN, ST_SETUP, ST_SHIFT, ST_HOLD, ST_GAP
  } state_t;

  state_t                state_reg, state_next;
  logic [CW-1:0]         cnt_reg, cnt_next;
  logic [3:0]            bit_reg, bit_next;
  logic                  half_reg, half_next;
  logic [FW-1:0]         frame_reg, frame_next;
  logic [FW-1:0]         rx_reg, rx_next;
  logic                  rd_reg, rd_next;
  logic [2:0]            ch_reg, ch_next;
  logic [NCH-1:0]        pending_reg, pending_next;
  logic [8*DATA_W-1:0]   data_reg, data_next;
  logic                  busy_reg, busy_next;
  logic                  done_reg, done_next;
  logic                  err_reg, err_next;
  logic [2:0]            err_ch_reg, err_ch_next;
  logic                  sclk_reg, sclk_next;
  logic                  cs_n_reg, cs_n_next;
  logic                  mosi_reg, mosi_next;

  logic                  nxt_found;
  logic [2:0]            nxt_ch;
  logic                  advance;
  logic                  unused_bits;

  // Build one frame: rw bit, wrapped 7-bit address, data (zero for reads).
  function automatic logic [FW-1:0] make_frame(input logic rw, input logic [2:0] ch,
                                               input logic [8*DATA_W-1:0] img);
    logic [6:0]        addr;
    logic [DATA_W-1:0] data;
    addr = 7'(BASE_ADDR + int'(ch));
    data = rw ? {DATA_W{1'b0}} : img[int'(ch)*DATA_W +: DATA_W];
    return {rw, addr, data};
  endfunction

  // Lowest-index channel still waiting to be loaded.
  always_comb begin
    nxt_found = 1'b0;
    nxt_ch    = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (pending_reg[i]) begin
        nxt_found = 1'b1;
        nxt_ch    = 3'(i);
      end
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    bit_next     = bit_reg;
    half_next    = half_reg;
    frame_next   = frame_reg;
    rx_next      = rx_reg;
    rd_next      = rd_reg;
    ch_next      = ch_reg;
    pending_next = pending_reg;
    data_next    = data_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    err_next     = err_reg;
    err_ch_next  = err_ch_reg;
    advance      = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next   = ST_SCAN;
          data_next    = ch_data;
          pending_next = ch_mask;
          busy_next    = 1'b1;
          err_next     = 1'b0;
          err_ch_next  = '0;
        end
      end
      ST_SCAN: advance = 1'b1;
      ST_SETUP: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_next   = '0;
          half_next  = 1'b0;
          bit_next   = '0;
          state_next = ST_SHIFT;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_SHIFT: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_next = '0;
          if (!half_reg) begin
            // sclk rises on this edge: capture miso together with the slave.
            half_next = 1'b1;
            rx_next   = {rx_reg[FW-2:0], miso};
          end else if (bit_reg == BIT_LAST) begin
            half_next  = 1'b0;
            state_next = ST_HOLD;
          end else begin
            // sclk falls: present the next bit while the clock is low.
            half_next  = 1'b0;
            bit_next   = bit_reg + 1'b1;
            frame_next = {frame_reg[FW-2:0], 1'b0};
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_next   = '0;
          state_next = ST_GAP;
`ifdef SPI_CFG_READBACK_EN
          if (rd_reg && (rx_reg[DATA_W-1:0] != data_reg[int'(ch_reg)*DATA_W +: DATA_W])) begin
            err_next = 1'b1;
            if (!err_reg) err_ch_next = ch_reg;
          end
`endif
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_next = '0;
`ifdef SPI_CFG_READBACK_EN
          if (!rd_reg) begin
            frame_next = make_frame(1'b1, ch_reg, data_reg);
            rd_next    = 1'b1;
            state_next = ST_SETUP;
          end else begin
            advance = 1'b1;
          end
`else
          advance = 1'b1;
`endif
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Move on to the next enabled channel, or finish the sequence.
    if (advance) begin
      if (nxt_found) begin
        frame_next           = make_frame(1'b0, nxt_ch, data_reg);
        ch_next              = nxt_ch;
        rd_next              = 1'b0;
        pending_next[nxt_ch] = 1'b0;
        cnt_next             = '0;
        state_next           = ST_SETUP;
      end else begin
        state_next = ST_IDLE;
        done_next  = 1'b1;
        busy_next  = 1'b0;
      end
    end
  end

  // Output decode from the upcoming state so the serial pins are registered.
  always_comb begin
    sclk_next = (state_next == ST_SHIFT) && half_next;
    cs_n_next = !((state_next == ST_SETUP) || (state_next == ST_SHIFT) ||
                  (state_next == ST_HOLD));
    mosi_next = cs_n_next ? 1'b0 : frame_next[FW-1];
  end

  // State register; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      bit_reg     <= '0;
      half_reg    <= 1'b0;
      frame_reg   <= '0;
      rx_reg      <= '0;
      rd_reg      <= 1'b0;
      ch_reg      <= '0;
      pending_reg <= '0;
      data_reg    <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
      err_ch_reg  <= '0;
      sclk_reg    <= 1'b0;
      cs_n_reg    <= 1'b1;
      mosi_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_reg     <= bit_next;
      half_reg    <= half_next;
      frame_reg   <= frame_next;
      rx_reg      <= rx_next;
      rd_reg      <= rd_next;
      ch_reg      <= ch_next;
      pending_reg <= pending_next;
      data_reg    <= data_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
      err_ch_reg  <= err_ch_next;
      sclk_reg    <= sclk_next;
      cs_n_reg    <= cs_n_next;
      mosi_reg    <= mosi_next;
    end
  end

  // Bits only consumed when readback compare is built in.
  assign unused_bits = ^{rx_reg, ch_reg, rd_reg};

  assign busy   = busy_reg;
  assign done   = done_reg;
  assign err    = err_reg;
  assign err_ch = err_ch_reg;
  assign sclk   = sclk_reg;
  assign cs_n   = cs_n_reg;
  assign mosi   = mosi_reg;

endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// tb_spi_cfg_sequencer: directed + randomized bench with an SPI slave model
// and a frame-list reference model for two instances (different divider/base).
module tb_spi_cfg_sequencer;

`ifdef SPI_CFG_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  localparam int CD0 = 2, BASE0 = 0;
  localparam int CD1 = 1, BASE1 = 127;

  logic        clk = 1'b0, rstn = 1'b0;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [63:0] ch_data = '0;
  logic [7:0]  ch_mask = '0;
  logic        miso = 1'b0;
  logic        busy0, done0, err0, sclk0, cs_n0, mosi0;
  logic        busy1, done1, err1, sclk1, cs_n1, mosi1;
  logic [2:0]  err_ch0, err_ch1;
  logic        sel = 1'b0;
  logic        sclk_s, cs_s, mosi_s, busy_s, done_s, err_s;
  logic [2:0]  err_ch_s;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  spi_cfg_sequencer #(.CLK_DIV(CD0), .BASE_ADDR(BASE0), .DATA_W(8)) dut0 (
    .clk(clk), .rstn(rstn), .start(start0), .ch_data(ch_data), .ch_mask(ch_mask),
    .busy(busy0), .done(done0), .err(err0), .err_ch(err_ch0),
    .sclk(sclk0), .cs_n(cs_n0), .mosi(mosi0), .miso(miso));

  spi_cfg_sequencer #(.CLK_DIV(CD1), .BASE_ADDR(BASE1), .DATA_W(8)) dut1 (
    .clk(clk), .rstn(rstn), .start(start1), .ch_data(ch_data), .ch_mask(ch_mask),
    .busy(busy1), .done(done1), .err(err1), .err_ch(err_ch1),
    .sclk(sclk1), .cs_n(cs_n1), .mosi(mosi1), .miso(miso));

  assign sclk_s   = sel ? sclk1   : sclk0;
  assign cs_s     = sel ? cs_n1   : cs_n0;
  assign mosi_s   = sel ? mosi1   : mosi0;
  assign busy_s   = sel ? busy1   : busy0;
  assign done_s   = sel ? done1   : done0;
  assign err_s    = sel ? err1    : err0;
  assign err_ch_s = sel ? err_ch1 : err_ch0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // SPI slave model: register file, frame capture, readback driver.
  logic [7:0]  sregs[128];
  logic [15:0] obs_q[$];
  logic [15:0] sh = '0;
  logic [7:0]  rd_byte = '0;
  logic        rd_frame = 1'b0;
  int          nbits = 0, cs_falls = 0, corrupt_addr = -1;

  always @(negedge cs_s) begin
    nbits = 0;
    rd_frame = 1'b0;
    cs_falls++;
  end

  always @(posedge sclk_s) begin
    if (cs_s === 1'b0) begin
      sh = {sh[14:0], mosi_s};
      nbits++;
    end
  end

  always @(negedge sclk_s) begin
    if (cs_s === 1'b0) begin
      if (nbits == 8) begin
        rd_frame = sh[7];
        rd_byte  = (int'(sh[6:0]) == corrupt_addr) ? 8'h00 : sregs[sh[6:0]];
      end
      if (rd_frame && nbits >= 8 && nbits < 16) miso = rd_byte[3'(15 - nbits)];
      else miso = 1'b0;
    end
  end

  always @(posedge cs_s) begin
    if (rstn === 1'b1 && nbits == 16) begin
      obs_q.push_back(sh);
      if (!sh[15]) sregs[sh[14:8]] = sh[7:0];
    end
    rd_frame = 1'b0;
    miso = 1'b0;
  end

  // mosi must not move while sclk stays high.
  logic sclk_p = 1'b0, mosi_p = 1'b0;
  always @(negedge clk) begin
    if (rstn && sclk_p && sclk_s && !cs_s) chk("mosi_hold", mosi_s, mosi_p);
    sclk_p = sclk_s;
    mosi_p = mosi_s;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One start/done sequence checked against the frame-list model.
  task automatic run_seq(input bit which, input logic [63:0] d, input logic [7:0] m,
                         input int intrude, input int corrupt_ch, input string tag);
    int cd, base, lat, cyc, busy_cnt, falls0, exp_ch;
    bit exp_err;
    logic [15:0] exp_q[$];
    logic [6:0] a;
    cd = which ? CD1 : CD0;
    base = which ? BASE1 : BASE0;
    sel = which;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        a = 7'(base + i);
        exp_q.push_back({1'b0, a, d[8*i +: 8]});
        if (RB) exp_q.push_back({1'b1, a, 8'h00});
        sregs[a] = ~d[8*i +: 8];
      end
    end
    exp_err = 1'b0;
    exp_ch = 0;
    corrupt_addr = -1;
    if (corrupt_ch >= 0) begin
      corrupt_addr = int'(7'(base + corrupt_ch));
      if (RB && m[corrupt_ch] && d[8*corrupt_ch +: 8] != 8'h00) begin
        exp_err = 1'b1;
        exp_ch = corrupt_ch;
      end
    end
    lat = 2 + exp_q.size() * 35 * cd;
    obs_q.delete();
    falls0 = cs_falls;
    ch_data = d;
    ch_mask = m;
    if (which) start1 = 1'b1; else start0 = 1'b1;
    cyc = 0;
    busy_cnt = 0;
    while (cyc < lat + 50) begin
      @(posedge clk);
      #1;
      start0 = 1'b0;
      start1 = 1'b0;
      cyc++;
      ch_data = {$urandom, $urandom};
      ch_mask = 8'($urandom);
      if (done_s === 1'b1) break;
      if (busy_s === 1'b1) busy_cnt++;
      if (cyc == intrude) begin
        if (which) start1 = 1'b1; else start0 = 1'b1;
      end
    end
    chk({tag, "_latency"}, cyc, lat);
    chk({tag, "_busy_width"}, busy_cnt, lat - 1);
    chk({tag, "_busy_at_done"}, busy_s, 1'b0);
    chk({tag, "_err"}, err_s, exp_err);
    chk({tag, "_err_ch"}, err_ch_s, exp_ch);
    chk({tag, "_frames"}, obs_q.size(), exp_q.size());
    chk({tag, "_cs_falls"}, cs_falls - falls0, exp_q.size());
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++)
      chk({tag, "_frame_word"}, obs_q[k], exp_q[k]);
    for (int i = 0; i < 8; i++)
      if (m[i]) chk({tag, "_slave_reg"}, sregs[7'(base + i)], d[8*i +: 8]);
    $display("run %s dut%0d mask=%h data=%h frames=%0d cycles=%0d err=%0b",
             tag, which, m, d, obs_q.size(), cyc, err_s);
  endtask

  logic [63:0] img;

  initial begin
    for (int i = 0; i < 128; i++) sregs[i] = 8'h00;

    // Reset values while rstn is held low.
    #12;
    chk("rst_busy", busy0, 1'b0);
    chk("rst_done", done0, 1'b0);
    chk("rst_err", err0, 1'b0);
    chk("rst_err_ch", err_ch0, 3'd0);
    chk("rst_sclk", sclk0, 1'b0);
    chk("rst_cs_n", cs_n0, 1'b1);
    chk("rst_mosi", mosi0, 1'b0);
    chk("rst_cs_n1", cs_n1, 1'b1);
    @(posedge clk);
    #1 rstn = 1'b1;
    idle(2);

    // Full load, then an empty mask started in the done cycle.
    for (int i = 0; i < 8; i++) img[8*i +: 8] = 8'hA0 + 8'(i);
    run_seq(1'b0, img, 8'hFF, 0, -1, "full_load");
    run_seq(1'b0, {$urandom, $urandom}, 8'h00, 0, -1, "empty_chained");
    idle(2);

    // Sparse mask with address wrap on the second instance.
    run_seq(1'b1, {$urandom, $urandom}, 8'h81, 0, -1, "sparse_wrap");
    idle(2);

    // Start pulse during a busy sequence must be ignored.
    run_seq(1'b0, {$urandom, $urandom}, 8'($urandom) | 8'h01, 40, -1, "start_busy");
    idle(2);

    // Randomized images and masks on both instances.
    for (int r = 0; r < 6; r++) begin
      run_seq(1'($urandom_range(0, 1)), {$urandom, $urandom}, 8'($urandom), 0, -1, "random");
      idle(2);
    end

    // Corrupted readback of channel 3, then a new start clears err.
    img = {$urandom, $urandom};
    img[31:24] = 8'h5A;
    run_seq(1'b0, img, 8'hFF, 0, 3, "readback_ch3");
    run_seq(1'b0, {$urandom, $urandom}, 8'h00, 0, -1, "err_clear");
    corrupt_addr = -1;
    idle(2);

    // Asynchronous reset in the middle of a shift.
    sel = 1'b0;
    ch_data = {$urandom, $urandom};
    ch_mask = 8'hFF;
    start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    repeat (19) @(posedge clk);
    #2;
    chk("pre_rst_cs_n", cs_n0, 1'b0);
    rstn = 1'b0;
    #1;
    chk("async_rst_cs_n", cs_n0, 1'b1);
    chk("async_rst_sclk", sclk0, 1'b0);
    chk("async_rst_busy", busy0, 1'b0);
    chk("async_rst_mosi", mosi0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_no_done", done0, 1'b0);
    end
    @(posedge clk);
    #1 rstn = 1'b1;
    idle(3);
    chk("post_rst_done", done0, 1'b0);
    chk("post_rst_busy", busy0, 1'b0);
    run_seq(1'b0, img, 8'hFF, 0, -1, "after_reset");
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
